// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg -- shared types and constants for the clock ratio meter.
//   state_t        : measurement FSM states (IDLE, ARM, MEAS)
//   DEFAULT_CNT_W  : default width of the period / high-time counters
//   max_cnt()      : largest value a counter of the given width can hold
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam int DEFAULT_CNT_W = 8;

  function automatic int max_cnt(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det -- brings an asynchronous level into the i_ref_clk domain and
// flags its rising edges.
//   i_ref_clk : reference clock, all flops on posedge
//   i_rst_n   : asynchronous active-low reset, clears the whole chain
//   d_async   : asynchronous input level
//   s         : synchronised level (output of the last synchroniser stage)
//   rise      : high for one cycle when s goes 0 -> 1
// Latency from d_async to s is fixed, so edge-to-edge distances are preserved.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_ref_clk,
  input  logic i_rst_n,
  input  logic d_async,
  output logic s,
  output logic rise
);

  // Fewer than two stages is not a synchroniser; clamp rather than break.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_reg;
  logic              s_d_reg;

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg <= '0;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d_async};
      s_d_reg  <= sync_reg[STAGES-1];
    end
  end

  assign s    = sync_reg[STAGES-1];
  assign rise = s & ~s_d_reg;

endmodule

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter -- measures the period and high time of a slow clock-like
// signal in whole reference-clock cycles.
//   i_ref_clk   : reference clock
//   i_rst_n     : asynchronous active-low reset
//   i_meas_en   : measurement enable (level); low returns to IDLE
//   i_mon_clk   : monitored signal, asynchronous to i_ref_clk
//   i_exp_ratio : expected period for the match check
//   o_ratio     : last measured period (rise to rise)
//   o_high_cnt  : synchronised-high cycles within that period
//   o_valid     : one-cycle pulse, o_ratio/o_high_cnt just updated
//   o_match     : updated with o_valid, o_ratio equals i_exp_ratio
//   o_timeout   : one-cycle pulse, no rising edge within MAX_CNT cycles
// Build option: define RATIO_MATCH_EN to enable o_match; otherwise o_match is
// tied low and i_exp_ratio is ignored.
module clk_ratio_meter
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_meas_en,
  input  logic             i_mon_clk,
  input  logic [4:0]       i_exp_ratio,
  output logic [CNT_W-1:0] o_ratio,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_valid,
  output logic             o_match,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_cnt(CNT_W));

  logic s;
  logic rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_ref_clk(i_ref_clk),
    .i_rst_n  (i_rst_n),
    .d_async  (i_mon_clk),
    .s        (s),
    .rise     (rise)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] p_cnt_reg, p_cnt_next;
  logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
  logic [CNT_W-1:0] ratio_reg, ratio_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             match_reg, match_next;
  logic             timeout_reg, timeout_next;
  logic             exp_hit;

`ifdef RATIO_MATCH_EN
  // Ratios of 0 and 1 are not physically measurable, so they never match.
  assign exp_hit = (i_exp_ratio > 5'd1) && (p_cnt_reg == CNT_W'(i_exp_ratio));
`else
  logic unused_exp_ratio;
  assign unused_exp_ratio = ^i_exp_ratio;
  assign exp_hit          = 1'b0;
`endif

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      p_cnt_reg   <= '0;
      h_cnt_reg   <= '0;
      ratio_reg   <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      match_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      p_cnt_reg   <= p_cnt_next;
      h_cnt_reg   <= h_cnt_next;
      ratio_reg   <= ratio_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      match_reg   <= match_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    p_cnt_next   = p_cnt_reg;
    h_cnt_next   = h_cnt_reg;
    ratio_next   = ratio_reg;
    high_next    = high_reg;
    match_next   = match_reg;
    valid_next   = 1'b0;
    timeout_next = 1'b0;

    if (!i_meas_en) begin
      // Disable wins over everything; results stay frozen.
      state_next = IDLE;
      p_cnt_next = '0;
      h_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = ARM;
          p_cnt_next = '0;
          h_cnt_next = '0;
        end
        ARM, MEAS: begin
          if (rise) begin
            // The rise cycle itself is the first cycle of the new period
            // and is always a high sample.
            p_cnt_next = CNT_W'(1);
            h_cnt_next = CNT_W'(1);
            state_next = MEAS;
            if (state_reg == MEAS) begin
              ratio_next = p_cnt_reg;
              high_next  = h_cnt_reg;
              match_next = exp_hit;
              valid_next = 1'b1;
            end
          end else if (p_cnt_reg == MAX_CNT) begin
            // Checked after rise so a rise exactly at MAX_CNT still measures.
            p_cnt_next   = '0;
            h_cnt_next   = '0;
            state_next   = ARM;
            timeout_next = 1'b1;
          end else begin
            p_cnt_next = p_cnt_reg + CNT_W'(1);
            h_cnt_next = h_cnt_reg + CNT_W'(s);
          end
        end
        default: begin
          state_next = IDLE;
          p_cnt_next = '0;
          h_cnt_next = '0;
        end
      endcase
    end
  end

  assign o_ratio    = ratio_reg;
  assign o_high_cnt = high_reg;
  assign o_valid    = valid_reg;
  assign o_match    = match_reg;
  assign o_timeout  = timeout_reg;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter -- self-checking bench for clk_ratio_meter (CNT_W = 8).
// A pattern generator drives i_mon_clk with programmable high/low lengths;
// expected measurements are queued when a pattern is applied and popped on
// each o_valid.
module tb_clk_ratio_meter;

  localparam int CNT_W = 8;
`ifdef RATIO_MATCH_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             meas_en = 1'b0;
  logic             mon_clk = 1'b0;
  logic [4:0]       exp_ratio = 5'd0;
  logic [CNT_W-1:0] o_ratio;
  logic [CNT_W-1:0] o_high_cnt;
  logic             o_valid;
  logic             o_match;
  logic             o_timeout;

  always #5 clk = ~clk;

  clk_ratio_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
    .i_meas_en  (meas_en),
    .i_mon_clk  (mon_clk),
    .i_exp_ratio(exp_ratio),
    .o_ratio    (o_ratio),
    .o_high_cnt (o_high_cnt),
    .o_valid    (o_valid),
    .o_match    (o_match),
    .o_timeout  (o_timeout)
  );

  // Pattern generator: one full period per iteration, settings sampled at
  // the start of each period.
  bit gen_on = 1'b0;
  int gen_hi = 2;
  int gen_lo = 2;
  int mon_rises = 0;

  initial begin
    forever begin
      if (!gen_on) begin
        @(posedge clk); #1 mon_clk = 1'b0;
      end else begin
        int hi, lo;
        hi = gen_hi;
        lo = gen_lo;
        for (int i = 0; i < hi; i++) begin
          @(posedge clk); #1 mon_clk = 1'b1;
          if (i == 0) mon_rises++;
        end
        for (int i = 0; i < lo; i++) begin
          @(posedge clk); #1 mon_clk = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int ratio;
    int high;
    bit match;
  } exp_t;

  typedef struct {
    int         hi;
    int         lo;
    logic [4:0] exp;
    int         ratio;
    int         high;
    bit         match;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tmo_cnt  = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Waits for the next o_valid, counting timeouts and catching collisions.
  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (o_timeout) tmo_cnt++;
      if (o_valid && o_timeout) check("valid_timeout_excl", 1, 0);
      if (o_valid) begin
        seen = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_pattern(input string name, input int hi, input int lo,
                             input logic [4:0] exp, input int ratio,
                             input int high, input bit match);
    bit   seen;
    exp_t e;
    gen_hi    = hi;
    gen_lo    = lo;
    exp_ratio = exp;
    gen_on    = 1'b1;
    // Let any period in flight and one transitional value drain.
    for (int k = 0; k < 3; k++) begin
      wait_valid(600, seen);
      if (!seen) check({name, "_settle_valid"}, 0, 1);
    end
    tmo_cnt = 0;
    for (int k = 0; k < 3; k++) sb_q.push_back('{ratio, high, match & MATCH_ON});
    while (sb_q.size() > 0) begin
      wait_valid(600, seen);
      if (!seen) begin
        check({name, "_valid_seen"}, 0, 1);
        sb_q.delete();
      end else begin
        e = sb_q.pop_front();
        check({name, "_ratio"}, int'(o_ratio), e.ratio);
        check({name, "_high"}, int'(o_high_cnt), e.high);
        check({name, "_match"}, int'(o_match), int'(e.match));
        $display("%s: ratio=%0d high=%0d match=%0b", name, o_ratio, o_high_cnt, o_match);
      end
    end
    check({name, "_no_timeout"}, tmo_cnt, 0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_ratio"}, int'(o_ratio), 0);
    check({name, "_high"}, int'(o_high_cnt), 0);
    check({name, "_valid"}, int'(o_valid), 0);
    check({name, "_match"}, int'(o_match), 0);
    check({name, "_timeout"}, int'(o_timeout), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int r0, pulses, valids, t_prev, n_tmo, held_ratio;

    vecs[0] = '{2, 2, 5'd4, 4, 2, 1'b1};
    vecs[1] = '{3, 3, 5'd6, 6, 3, 1'b1};     // 4 -> 6 switch on the fly
    vecs[2] = '{2, 3, 5'd4, 5, 2, 1'b0};
    vecs[3] = '{2, 3, 5'd5, 5, 2, 1'b1};
    vecs[4] = '{1, 1, 5'd2, 2, 1, 1'b1};     // fastest measurable signal
    vecs[5] = '{1, 1, 5'd1, 2, 1, 1'b0};
    vecs[6] = '{5, 7, 5'd12, 12, 5, 1'b1};
    vecs[7] = '{3, 4, 5'd0, 7, 3, 1'b0};
    vecs[8] = '{100, 155, 5'd31, 255, 100, 1'b0}; // rise exactly at MAX_CNT

    // Reset state
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    meas_en = 1'b1;

    for (int i = 0; i < 9; i++)
      run_pattern($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].exp,
                  vecs[i].ratio, vecs[i].high, vecs[i].match);

    // Enable dropped mid-measurement: results freeze, no pulses.
    run_pattern("pre_en_drop", 2, 2, 5'd4, 4, 2, 1'b1);
    @(negedge clk);
    meas_en = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid || o_timeout) pulses++;
    end
    check("en_off_pulses", pulses, 0);
    check("en_off_ratio_hold", int'(o_ratio), 4);
    check("en_off_high_hold", int'(o_high_cnt), 2);
    $display("en_off: pulses=%0d ratio=%0d high=%0d", pulses, o_ratio, o_high_cnt);
    gen_on = 1'b0;
    repeat (10) @(negedge clk);
    meas_en = 1'b1;
    repeat (5) @(negedge clk);
    r0 = mon_rises;
    gen_on = 1'b1;
    wait_valid(100, seen);
    check("reenable_valid_seen", int'(seen), 1);
    check("reenable_rises_before_valid", mon_rises - r0, 2);
    check("reenable_ratio", int'(o_ratio), 4);
    $display("reenable: rises=%0d ratio=%0d", mon_rises - r0, o_ratio);

    // Monitored signal stuck low: periodic timeouts, results held.
    gen_on = 1'b0;
    repeat (10) @(negedge clk);
    held_ratio = int'(o_ratio);
    valids = 0;
    n_tmo  = 0;
    t_prev = -1;
    for (int c = 0; c < 900 && n_tmo < 3; c++) begin
      @(negedge clk);
      if (o_valid) valids++;
      if (o_timeout) begin
        n_tmo++;
        if (t_prev >= 0) check($sformatf("timeout_interval%0d", n_tmo), c - t_prev, 256);
        $display("timeout %0d at cycle %0d", n_tmo, c);
        t_prev = c;
      end
    end
    check("timeout_count", n_tmo, 3);
    check("timeout_no_valid", valids, 0);
    check("timeout_ratio_hold", int'(o_ratio), held_ratio);

    // Recovery after timeouts
    run_pattern("recover", 2, 2, 5'd4, 4, 2, 1'b1);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    gen_on = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    $display("async_rst: ratio=%0d high=%0d valid=%0b", o_ratio, o_high_cnt, o_valid);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    r0 = mon_rises;
    gen_on = 1'b1;
    wait_valid(100, seen);
    check("post_rst_valid_seen", int'(seen), 1);
    check("post_rst_rises_before_valid", mon_rises - r0, 2);
    check("post_rst_ratio", int'(o_ratio), 4);
    check("post_rst_high", int'(o_high_cnt), 2);
    $display("post_rst: ratio=%0d high=%0d", o_ratio, o_high_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
